// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory-stage engine.
//   - access size encodings (SZ_B/SZ_H/SZ_W/SZ_D)
//   - FSM state enum for mem_access_unit
//   - held-instruction record kept while a transaction is outstanding
//   - byte-enable and alignment helpers
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Everything the DONE cycle and the load extender need about the
    // instruction that launched the transaction.
    typedef struct packed {
        logic        rwe;
        logic        m2r;
        logic [4:0]  rd;
        logic [63:0] alu;
        logic [1:0]  size;
        logic        uns;
        logic [2:0]  off;
    } hold_t;

    // Contiguous byte mask of the access width, shifted into its lane.
    // Bits shifted past lane 7 are dropped.
    function automatic logic [7:0] be_mask(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        logic [2:0] m;
        case (size)
            SZ_B:    m = 3'b000;
            SZ_H:    m = 3'b001;
            SZ_W:    m = 3'b011;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational lane steering for the memory stage.
//   Store side: st_size_i/st_off_i/st_data_i -> be_o (byte enables),
//               wdata_o (data shifted into its byte lanes).
//   Load side:  ld_size_i/ld_off_i/ld_uns_i/rdata_i -> load_o (selected
//               bytes right-justified, sign- or zero-extended to 64 bits).
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [2:0]  st_off_i,
    input  logic [63:0] st_data_i,
    output logic [7:0]  be_o,
    output logic [63:0] wdata_o,
    input  logic [1:0]  ld_size_i,
    input  logic [2:0]  ld_off_i,
    input  logic        ld_uns_i,
    input  logic [63:0] rdata_i,
    output logic [63:0] load_o
);

    logic [63:0] ld_sh;

    assign be_o    = be_mask(st_size_i, st_off_i);
    assign wdata_o = st_data_i << {st_off_i, 3'b000};
    assign ld_sh   = rdata_i >> {ld_off_i, 3'b000};

    always_comb begin
        load_o = ld_sh;
        case (ld_size_i)
            SZ_B:    load_o = {{56{ld_sh[7]  & ~ld_uns_i}}, ld_sh[7:0]};
            SZ_H:    load_o = {{48{ld_sh[15] & ~ld_uns_i}}, ld_sh[15:0]};
            SZ_W:    load_o = {{32{ld_sh[31] & ~ld_uns_i}}, ld_sh[31:0]};
            default: load_o = ld_sh;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage engine between EX/MEM and MEM/WB.
//   Inputs : EX/MEM instruction (valid_i, mem_read_i, mem_write_i, size_i,
//            unsigned_i, reg_write_en_i, mem_to_reg_i, reg_write_addr_i,
//            alu_i, store_data_i) and data-memory response (dmem_ack_i,
//            dmem_rdata_i).
//   Outputs: stall_o (freeze upstream), misalign_o, the data-memory request
//            (dmem_req_o/we/addr/be/wdata, registered) and the MEM/WB
//            inputs (reg_write_en_o, mem_to_reg_o, reg_write_addr_o, alu_o,
//            load_data_o).
//   FSM: IDLE -> BUSY (request outstanding) -> DONE (hand result to MEM/WB).
module mem_access_unit
    import mem_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic        reg_write_en_i,
    input  logic        mem_to_reg_i,
    input  logic [4:0]  reg_write_addr_i,
    input  logic [63:0] alu_i,
    input  logic [63:0] store_data_i,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [63:0] dmem_addr_o,
    output logic [7:0]  dmem_be_o,
    output logic [63:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [63:0] dmem_rdata_i,
    output logic        reg_write_en_o,
    output logic        mem_to_reg_o,
    output logic [4:0]  reg_write_addr_o,
    output logic [63:0] alu_o,
    output logic [63:0] load_data_o
);

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [63:0] addr_q, addr_d;
    logic [7:0]  be_q, be_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] load_q, load_d;
    hold_t       hold_q, hold_d;

    logic        mem_op, aligned, stall, misalign;
    logic [7:0]  be_w;
    logic [63:0] wdata_w, load_w;

    assign mem_op  = valid_i & (mem_read_i | mem_write_i);
    assign aligned = (alu_i[2:0] & align_mask(size_i)) == 3'b000;

    // Store lanes come from the live instruction (used at launch); load
    // extension uses the held copy because ack arrives cycles later.
    mem_lane_align u_align (
        .st_size_i (size_i),
        .st_off_i  (alu_i[2:0]),
        .st_data_i (store_data_i),
        .be_o      (be_w),
        .wdata_o   (wdata_w),
        .ld_size_i (hold_q.size),
        .ld_off_i  (hold_q.off),
        .ld_uns_i  (hold_q.uns),
        .rdata_i   (dmem_rdata_i),
        .load_o    (load_w)
    );

    always_comb begin
        state_d          = state_q;
        req_d            = req_q;
        we_d             = we_q;
        addr_d           = addr_q;
        be_d             = be_q;
        wdata_d          = wdata_q;
        load_d           = load_q;
        hold_d           = hold_q;
        stall            = 1'b0;
        misalign         = 1'b0;
        reg_write_en_o   = valid_i & reg_write_en_i;
        mem_to_reg_o     = mem_to_reg_i;
        reg_write_addr_o = reg_write_addr_i;
        alu_o            = alu_i;
        load_data_o      = load_q;

        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    if (aligned) begin
                        stall       = 1'b1;
                        state_d     = BUSY;
                        req_d       = 1'b1;
                        we_d        = mem_write_i;
                        addr_d      = {alu_i[63:3], 3'b000};
                        be_d        = be_w;
                        wdata_d     = wdata_w;
                        hold_d.rwe  = valid_i & reg_write_en_i;
                        hold_d.m2r  = mem_to_reg_i;
                        hold_d.rd   = reg_write_addr_i;
                        hold_d.alu  = alu_i;
                        hold_d.size = size_i;
                        hold_d.uns  = unsigned_i;
                        hold_d.off  = alu_i[2:0];
                    end else begin
                        misalign       = 1'b1;
                        reg_write_en_o = 1'b0;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (dmem_ack_i) begin
                    load_d  = load_w;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d          = IDLE;
                reg_write_en_o   = hold_q.rwe;
                mem_to_reg_o     = hold_q.m2r;
                reg_write_addr_o = hold_q.rd;
                alu_o            = hold_q.alu;
            end
            default: state_d = IDLE;
        endcase

        // MEM/WB must capture a bubble while upstream is frozen.
        if (stall) begin
            reg_write_en_o = 1'b0;
            mem_to_reg_o   = 1'b0;
        end
    end

    // Gated by reset so these drop immediately, even with a memory op
    // still sitting on the inputs.
    assign stall_o    = stall & rst_ni;
    assign misalign_o = misalign & rst_ni;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            load_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            load_q  <= load_d;
            hold_q  <= hold_d;
        end
    end

    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_be_o    = be_q;
    assign dmem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, mem_read, mem_write, uns, rwe, m2r;
    logic [1:0]  size;
    logic [4:0]  rd;
    logic [63:0] alu, sdata;
    logic        stall_o, misalign_o, dmem_req_o, dmem_we_o;
    logic [63:0] dmem_addr_o, dmem_wdata_o;
    logic [7:0]  dmem_be_o;
    logic        ack;
    logic [63:0] rdata;
    logic        rwe_o, m2r_o;
    logic [4:0]  rd_o;
    logic [63:0] alu_o, load_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .valid_i          (valid),
        .mem_read_i       (mem_read),
        .mem_write_i      (mem_write),
        .size_i           (size),
        .unsigned_i       (uns),
        .reg_write_en_i   (rwe),
        .mem_to_reg_i     (m2r),
        .reg_write_addr_i (rd),
        .alu_i            (alu),
        .store_data_i     (sdata),
        .stall_o          (stall_o),
        .misalign_o       (misalign_o),
        .dmem_req_o       (dmem_req_o),
        .dmem_we_o        (dmem_we_o),
        .dmem_addr_o      (dmem_addr_o),
        .dmem_be_o        (dmem_be_o),
        .dmem_wdata_o     (dmem_wdata_o),
        .dmem_ack_i       (ack),
        .dmem_rdata_i     (rdata),
        .reg_write_en_o   (rwe_o),
        .mem_to_reg_o     (m2r_o),
        .reg_write_addr_o (rd_o),
        .alu_o            (alu_o),
        .load_data_o      (load_o)
    );

    task clear_inputs();
        valid = 0; mem_read = 0; mem_write = 0; size = 0; uns = 0;
        rwe = 0; m2r = 0; rd = 0; alu = 0; sdata = 0; ack = 0; rdata = 0;
    endtask

    task next_cycle();
        @(posedge clk); #1;
    endtask

    task test_reset();
        rst_n = 0;
        clear_inputs();
        // aligned load on the inputs while in reset: stall must stay low
        valid = 1; mem_read = 1; size = 2'd3; alu = 64'h8;
        #3;
        checks++; if (dmem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", dmem_req_o); end
        checks++; if (dmem_we_o !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", dmem_we_o); end
        checks++; if (dmem_addr_o !== 64'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", dmem_addr_o); end
        checks++; if (dmem_be_o !== 8'h0) begin errors++; $display("FAIL rst_be got %h exp 0", dmem_be_o); end
        checks++; if (dmem_wdata_o !== 64'h0) begin errors++; $display("FAIL rst_wdata got %h exp 0", dmem_wdata_o); end
        checks++; if (load_o !== 64'h0) begin errors++; $display("FAIL rst_load got %h exp 0", load_o); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", stall_o); end
        checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL rst_misalign got %b exp 0", misalign_o); end
        clear_inputs();
        next_cycle();
        next_cycle();
        rst_n = 1;
    endtask

    task test_lb_sext();
        int stalls;
        stalls = 0;
        next_cycle();
        valid = 1; mem_read = 1; size = 2'd0; uns = 0; rwe = 1; m2r = 1; rd = 5'd7; alu = 64'h1005;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin ack = 1; rdata = 64'h0000_80FF_0000_0000; end
            @(negedge clk);
            if (stall_o === 1'b1) stalls++;
            checks++; if (rwe_o !== 1'b0 || m2r_o !== 1'b0) begin errors++; $display("FAIL lb_bubble c=%0d got rwe=%b m2r=%b exp 0 0", c, rwe_o, m2r_o); end
            if (c == 1) begin
                checks++; if (dmem_req_o !== 1'b1) begin errors++; $display("FAIL lb_req got %b exp 1", dmem_req_o); end
                checks++; if (dmem_addr_o !== 64'h1000) begin errors++; $display("FAIL lb_addr got %h exp 1000", dmem_addr_o); end
                checks++; if (dmem_be_o !== 8'h20) begin errors++; $display("FAIL lb_be got %h exp 20", dmem_be_o); end
                checks++; if (dmem_we_o !== 1'b0) begin errors++; $display("FAIL lb_we got %b exp 0", dmem_we_o); end
            end
            next_cycle();
            ack = 0; rdata = 0;
        end
        @(negedge clk);
        checks++; if (stalls !== 4) begin errors++; $display("FAIL lb_stall_cycles got %0d exp 4", stalls); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL lb_done_stall got %b exp 0", stall_o); end
        checks++; if (load_o !== 64'hFFFF_FFFF_FFFF_FF80) begin errors++; $display("FAIL lb_load got %h exp ffffffffffffff80", load_o); end
        checks++; if (rwe_o !== 1'b1 || m2r_o !== 1'b1 || rd_o !== 5'd7) begin errors++; $display("FAIL lb_done_ctl got rwe=%b m2r=%b rd=%0d exp 1 1 7", rwe_o, m2r_o, rd_o); end
        checks++; if (alu_o !== 64'h1005) begin errors++; $display("FAIL lb_done_alu got %h exp 1005", alu_o); end
        checks++; if (dmem_req_o !== 1'b0) begin errors++; $display("FAIL lb_done_req got %b exp 0", dmem_req_o); end
        next_cycle();
        clear_inputs();
    endtask

    task test_sh_store();
        next_cycle();
        valid = 1; mem_write = 1; size = 2'd1; sdata = 64'hABCD; alu = 64'h2006;
        @(negedge clk);
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL sh_stall0 got %b exp 1", stall_o); end
        next_cycle();
        ack = 1;
        @(negedge clk);
        checks++; if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b1) begin errors++; $display("FAIL sh_req_we got %b %b exp 1 1", dmem_req_o, dmem_we_o); end
        checks++; if (dmem_addr_o !== 64'h2000) begin errors++; $display("FAIL sh_addr got %h exp 2000", dmem_addr_o); end
        checks++; if (dmem_be_o !== 8'hC0) begin errors++; $display("FAIL sh_be got %h exp c0", dmem_be_o); end
        checks++; if (dmem_wdata_o !== 64'hABCD_0000_0000_0000) begin errors++; $display("FAIL sh_wdata got %h exp abcd000000000000", dmem_wdata_o); end
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL sh_stall1 got %b exp 1", stall_o); end
        next_cycle();
        ack = 0;
        @(negedge clk);
        checks++; if (stall_o !== 1'b0 || rwe_o !== 1'b0) begin errors++; $display("FAIL sh_done got stall=%b rwe=%b exp 0 0", stall_o, rwe_o); end
        checks++; if (dmem_req_o !== 1'b0) begin errors++; $display("FAIL sh_done_req got %b exp 0", dmem_req_o); end
        next_cycle();
        clear_inputs();
    endtask

    task test_misalign();
        next_cycle();
        valid = 1; mem_read = 1; size = 2'd2; rwe = 1; m2r = 1; rd = 5'd4; alu = 64'h3002;
        @(negedge clk);
        checks++; if (misalign_o !== 1'b1) begin errors++; $display("FAIL mis_flag got %b exp 1", misalign_o); end
        checks++; if (stall_o !== 1'b0 || rwe_o !== 1'b0) begin errors++; $display("FAIL mis_ctl got stall=%b rwe=%b exp 0 0", stall_o, rwe_o); end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++; if (misalign_o !== 1'b0 || dmem_req_o !== 1'b0) begin errors++; $display("FAIL mis_after got mis=%b req=%b exp 0 0", misalign_o, dmem_req_o); end
        // half at odd address is also misaligned
        next_cycle();
        valid = 1; mem_write = 1; size = 2'd1; alu = 64'h3003;
        @(negedge clk);
        checks++; if (misalign_o !== 1'b1 || stall_o !== 1'b0) begin errors++; $display("FAIL mis_half got mis=%b stall=%b exp 1 0", misalign_o, stall_o); end
        next_cycle();
        clear_inputs();
    endtask

    task test_alu_op();
        next_cycle();
        valid = 1; rwe = 1; rd = 5'd3; alu = 64'h55;
        @(negedge clk);
        checks++; if (rwe_o !== 1'b1 || alu_o !== 64'h55 || rd_o !== 5'd3) begin errors++; $display("FAIL alu_pass got rwe=%b alu=%h rd=%0d exp 1 55 3", rwe_o, alu_o, rd_o); end
        checks++; if (stall_o !== 1'b0 || misalign_o !== 1'b0) begin errors++; $display("FAIL alu_stall got %b %b exp 0 0", stall_o, misalign_o); end
        valid = 0;
        #1;
        checks++; if (rwe_o !== 1'b0) begin errors++; $display("FAIL alu_invalid got rwe=%b exp 0", rwe_o); end
        next_cycle();
        clear_inputs();
    endtask

    task test_reset_mid();
        next_cycle();
        valid = 1; mem_read = 1; size = 2'd3; rwe = 1; rd = 5'd2; alu = 64'h5000;
        next_cycle();
        checks++; if (dmem_req_o !== 1'b1 || stall_o !== 1'b1) begin errors++; $display("FAIL rm_busy got req=%b stall=%b exp 1 1", dmem_req_o, stall_o); end
        #2 rst_n = 0;
        #1;
        checks++; if (dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL rm_drop got req=%b stall=%b exp 0 0", dmem_req_o, stall_o); end
        clear_inputs();
        next_cycle();
        rst_n = 1;
        ack = 1; rdata = 64'hDEAD_BEEF_0000_1111; alu = 64'h77;
        @(negedge clk);
        checks++; if (stall_o !== 1'b0 || dmem_req_o !== 1'b0) begin errors++; $display("FAIL rm_stale got stall=%b req=%b exp 0 0", stall_o, dmem_req_o); end
        next_cycle();
        ack = 0; rdata = 0;
        @(negedge clk);
        checks++; if (load_o !== 64'h0) begin errors++; $display("FAIL rm_load got %h exp 0", load_o); end
        checks++; if (alu_o !== 64'h77 || rwe_o !== 1'b0) begin errors++; $display("FAIL rm_nodone got alu=%h rwe=%b exp 77 0", alu_o, rwe_o); end
        next_cycle();
        clear_inputs();
    endtask

    task test_ld_unsigned();
        next_cycle();
        valid = 1; mem_read = 1; size = 2'd3; uns = 1; rwe = 1; m2r = 1; rd = 5'd9; alu = 64'h4000;
        next_cycle();
        ack = 1; rdata = 64'h8000_0000_0000_0001;
        @(negedge clk);
        checks++; if (dmem_be_o !== 8'hFF || dmem_addr_o !== 64'h4000) begin errors++; $display("FAIL ld_req got be=%h addr=%h exp ff 4000", dmem_be_o, dmem_addr_o); end
        next_cycle();
        ack = 0; rdata = 0;
        @(negedge clk);
        checks++; if (load_o !== 64'h8000_0000_0000_0001) begin errors++; $display("FAIL ld_load got %h exp 8000000000000001", load_o); end
        checks++; if (rwe_o !== 1'b1 || rd_o !== 5'd9) begin errors++; $display("FAIL ld_done got rwe=%b rd=%0d exp 1 9", rwe_o, rd_o); end
        next_cycle();
        clear_inputs();
        ack = 1; rdata = 64'h1234;
        @(negedge clk);
        checks++; if (stall_o !== 1'b0 || dmem_req_o !== 1'b0) begin errors++; $display("FAIL ld_stray got stall=%b req=%b exp 0 0", stall_o, dmem_req_o); end
        next_cycle();
        ack = 0; rdata = 0;
        @(negedge clk);
        checks++; if (load_o !== 64'h8000_0000_0000_0001) begin errors++; $display("FAIL ld_stray_load got %h exp 8000000000000001", load_o); end
    endtask

    task test_back_to_back();
        next_cycle();
        valid = 1; mem_write = 1; size = 2'd0; sdata = 64'h5A; alu = 64'h6003;
        next_cycle();
        ack = 1;
        @(negedge clk);
        checks++; if (dmem_be_o !== 8'h08 || dmem_wdata_o !== 64'h5A00_0000) begin errors++; $display("FAIL b2b_sb got be=%h wdata=%h exp 08 5a000000", dmem_be_o, dmem_wdata_o); end
        next_cycle();
        ack = 0;
        @(negedge clk);
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL b2b_done1 got stall=%b exp 0", stall_o); end
        next_cycle();
        // second op presented on the cycle right after DONE
        clear_inputs();
        valid = 1; mem_read = 1; size = 2'd1; uns = 0; rwe = 1; m2r = 1; rd = 5'd12; alu = 64'h6002;
        @(negedge clk);
        checks++; if (stall_o !== 1'b1 || dmem_req_o !== 1'b0) begin errors++; $display("FAIL b2b_launch got stall=%b req=%b exp 1 0", stall_o, dmem_req_o); end
        next_cycle();
        ack = 1; rdata = 64'h0000_0000_F00D_0000;
        @(negedge clk);
        checks++; if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b0 || dmem_be_o !== 8'h0C) begin errors++; $display("FAIL b2b_lh_req got req=%b we=%b be=%h exp 1 0 0c", dmem_req_o, dmem_we_o, dmem_be_o); end
        next_cycle();
        ack = 0; rdata = 0;
        @(negedge clk);
        checks++; if (load_o !== 64'hFFFF_FFFF_FFFF_F00D) begin errors++; $display("FAIL b2b_lh_load got %h exp fffffffffffff00d", load_o); end
        checks++; if (rwe_o !== 1'b1 || rd_o !== 5'd12 || stall_o !== 1'b0) begin errors++; $display("FAIL b2b_done2 got rwe=%b rd=%0d stall=%b exp 1 12 0", rwe_o, rd_o, stall_o); end
        next_cycle();
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_lb_sext();
        test_sh_store();
        test_misalign();
        test_alu_op();
        test_reset_mid();
        test_ld_unsigned();
        test_back_to_back();
        next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage engine of the 64-bit pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register. It turns load/store requests into a req/ack data-memory transaction, stalls upstream stages while the transaction is outstanding, and aligns and extends load data. Its outputs feed the MEM/WB register's inputs directly.

## Interface
- No parameters; data width is fixed at 64, register address at 5.
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- valid_i  in  1  instruction present from EX/MEM
- mem_read_i / mem_write_i  in  1 each  load / store (never both)
- size_i  in  2  access size: 0=byte, 1=half, 2=word, 3=dword
- unsigned_i  in  1  zero-extend loads (else sign-extend)
- reg_write_en_i, mem_to_reg_i  in  1 each  writeback controls
- reg_write_addr_i  in  5  destination register
- alu_i  in  64  ALU result / effective address
- store_data_i  in  64  store operand, right-justified
- stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- misalign_o  out  1  one-cycle misaligned-access flag
- dmem_req_o, dmem_we_o  out  1 each  request / write strobe
- dmem_addr_o  out  64  dword-aligned address
- dmem_be_o  out  8  byte enables
- dmem_wdata_o  out  64  lane-shifted write data
- dmem_ack_i  in  1  transaction complete; read data valid this cycle
- dmem_rdata_i  in  64  raw read dword
- reg_write_en_o, mem_to_reg_o, reg_write_addr_o, alu_o, load_data_o  out  1/1/5/64/64  to MEM/WB

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- Memory operation: a memory op is valid_i & (mem_read_i | mem_write_i).
- Aligned: alu_i[2:0] mod (1<<size_i) == 0.
- IDLE transitions:
  - Aligned memory op: stall_o=1, go to BUSY. The request registers load at this clock edge.
  - Misaligned memory op: misalign_o=1, no request, no stall, reg_write_en_o=0.
  - Otherwise: pass-through with zero stall.
- BUSY:
  - dmem_req_o=1 with stable addr/we/be/wdata; stall_o=1.
  - On dmem_ack_i: capture the extended load into load_q, drop req at the edge, go to DONE.
- DONE:
  - stall_o=0.
  - Outputs carry the held instruction's controls, and load_data_o=load_q.
  - MEM/WB captures them and upstream advances on the same edge; next state is IDLE.
- Bubble rule: while stall_o=1, reg_write_en_o=0 and mem_to_reg_o=0, so MEM/WB captures a bubble.
- Pass-through: reg_write_en_o = valid_i & reg_write_en_i. All other controls and alu_o are copied combinationally.
- Lane rules, with off=alu_i[2:0]:
  - dmem_addr_o = {alu_i[63:3],3'b000}
  - dmem_be_o = ((1<<(1<<size_i))-1) << off, truncated to 8 bits
  - dmem_wdata_o = store_data_i << (8*off)
- Load: shift dmem_rdata_i right by 8*off, truncate to the access size, then sign- or zero-extend to 64 bits.
- dmem_ack_i outside BUSY is ignored.
- Reset asserted in any state: IDLE immediately. dmem_req_o, stall_o and misalign_o go to 0 asynchronously. A later stale ack is ignored.

## Timing
- Reset values: dmem_req_o=0, dmem_we_o=0, dmem_addr_o=0, dmem_be_o=0, dmem_wdata_o=0, load_q=0, stall_o=0, misalign_o=0.
- Memory op with ack arriving N≥1 cycles after req rises: stall_o high for 1+N cycles, then one DONE cycle.
- Total occupancy is N+2 cycles.
- Non-memory op: 0 added cycles; outputs are combinational from inputs.
- Registered outputs: dmem_* and load_q. Combinational outputs: stall_o, misalign_o, writeback outputs.
- Ack in the same cycle req first rises (N=1) is legal.
- Back-to-back memory ops: the second one is seen in IDLE on the cycle after DONE.

## Structure
- Shared package mem_pkg holds:
  - the size encodings (SZ_B, SZ_H, SZ_W, SZ_D)
  - the FSM state enum
  - the byte-enable helper function
- One sub-module, mem_lane_align (combinational), performs store shift and byte-enable generation, and load shift and extension. The FSM, registers and stall logic live in mem_access_unit.

## Test plan
- Byte load sign-extend: lb at alu_i=0x1005, signed, rdata=0x0000_80FF_0000_0000, ack after 3 cycles.
  - dmem_addr_o=0x1000, be=0x20, stall_o high 4 cycles.
  - DONE: load_data_o=0xFFFF_FFFF_FFFF_FF80, reg_write_en_o=1.
- Half store: sh at alu_i=0x2006, data 0xABCD, ack=1 cycle.
  - be=0xC0, wdata=0xABCD_0000_0000_0000, we=1, reg_write_en_o=0 in DONE.
- Misaligned word load: lw at alu_i=0x3002.
  - misalign_o=1 one cycle, no dmem_req_o, stall_o=0, reg_write_en_o=0.
- ALU op: valid, reg_write_en_i=1, alu_i=0x55.
  - Same cycle: reg_write_en_o=1, alu_o=0x55, stall_o=0.
- Reset mid-transaction: rst_ni low during BUSY.
  - dmem_req_o and stall_o drop before the next edge; state is IDLE.
  - An ack after reset release produces no DONE and no write.
- Unsigned dword load: ld at 0x4000, unsigned, ack with rdata=0x8000_0000_0000_0001.
  - load_data_o equals rdata; stray ack in IDLE has no effect.
